// File: rtl/alu_op_dispatch.sv
// Issue-side ALU dispatcher: latches one op, starts the selected unit, waits for it,
// then holds the result on a valid/ready write-back port. Optional macro: ALU_DISPATCH_TIMEOUT_EN.
module alu_op_dispatch #(
  parameter int          WIDTH       = 16,
  parameter int          TAG_W       = 4,
  parameter logic [3:0]  COMB_UNITS  = 4'b0011,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_opcode,
  input  logic [WIDTH-1:0] req_rs1,
  input  logic [WIDTH-1:0] req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  output logic [3:0]       unit_start,
  input  logic [3:0]       unit_done,
  input  logic [WIDTH-1:0] add_rd,
  input  logic [WIDTH-1:0] sub_rd,
  input  logic [WIDTH-1:0] mul_rd,
  input  logic [WIDTH-1:0] div_rd,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [WIDTH-1:0] wb_data,
  output logic [TAG_W-1:0] wb_tag,
  output logic             wb_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB
  } state_t;

  localparam logic [1:0] OP_DIV = 2'b11;

  state_t           state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] sel_rd;

`ifdef ALU_DISPATCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);
  logic [CNT_W-1:0] wait_cnt;
`else
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end
`endif

  always_comb begin
    sel_rd = add_rd;
    case (op_q)
      2'b00:   sel_rd = add_rd;
      2'b01:   sel_rd = sub_rd;
      2'b10:   sel_rd = mul_rd;
      default: sel_rd = div_rd;
    endcase
  end

  // Outputs are registered alongside state so they change only on clock edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= '0;
      unit_a     <= '0;
      unit_b     <= '0;
      unit_start <= '0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_tag     <= '0;
      wb_err     <= 1'b0;
      busy       <= 1'b0;
      req_ready  <= 1'b1;
`ifdef ALU_DISPATCH_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q      <= req_opcode;
            wb_tag    <= req_tag;
            unit_a    <= req_rs1;
            unit_b    <= req_rs2;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= S_ISSUE;
            // Divide by zero is resolved locally, so the divider is never started.
            if (!(req_opcode == OP_DIV && req_rs2 == '0)) begin
              unit_start <= 4'b0001 << req_opcode;
            end
          end
        end

        S_ISSUE: begin
          unit_start <= '0;
          if (op_q == OP_DIV && unit_b == '0) begin
            wb_data  <= '1;
            wb_err   <= 1'b1;
            wb_valid <= 1'b1;
            state    <= S_WB;
          end else if (COMB_UNITS[op_q]) begin
            wb_data  <= sel_rd;
            wb_err   <= 1'b0;
            wb_valid <= 1'b1;
            state    <= S_WB;
          end else begin
            state <= S_WAIT;
`ifdef ALU_DISPATCH_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end

        S_WAIT: begin
          if (unit_done[op_q]) begin
            wb_data  <= sel_rd;
            wb_err   <= 1'b0;
            wb_valid <= 1'b1;
            state    <= S_WB;
          end
`ifdef ALU_DISPATCH_TIMEOUT_EN
          else if (wait_cnt == CNT_LIMIT) begin
            wb_data  <= '0;
            wb_err   <= 1'b1;
            wb_valid <= 1'b1;
            state    <= S_WB;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        S_WB: begin
          if (wb_ready) begin
            wb_valid  <= 1'b0;
            wb_err    <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
